// File: rtl/adc_muestreo_if.sv
// adc_muestreo_if: SPI link to the serial ADC plus the sample/strobe outputs
// consumed by the filter bank. The master modport is the sampler side.
interface adc_muestreo_if #(
    parameter int cant_bits = 25
);
    logic                 miso;
    logic                 sclk;
    logic                 cs_n;
    logic [cant_bits-1:0] u;
    logic                 rx;
    logic                 overrun;

    modport master (
        input  miso,
        output sclk,
        output cs_n,
        output u,
        output rx,
        output overrun
    );

    modport slave (
        output miso,
        input  sclk,
        input  cs_n,
        input  u,
        input  rx,
        input  overrun
    );
endinterface

// File: rtl/adc_muestreo.sv
// adc_muestreo: fixed-rate sampler for an ADCS7476-type serial ADC.
// Every muestra_ciclos clocks a 16-sclk frame is read MSB-first, the
// offset-binary code is converted to signed fixed point and presented on u
// with a one-cycle rx strobe.
// Optional build macro: ADC_OVERRUN_EN (sticky detection of ticks that land
// while a frame is still in flight); without it overrun is tied low.
module adc_muestreo #(
    parameter int cant_bits      = 25,
    parameter int frac_bits      = 15,
    parameter int adc_bits       = 12,
    parameter int muestra_ciclos = 2268,
    parameter int div_sclk       = 3
) (
    input  logic            clk,
    input  logic            rst,
    adc_muestreo_if.master  bus
);
    localparam int TW    = $clog2(muestra_ciclos);
    localparam int HW    = (div_sclk > 1) ? $clog2(div_sclk) : 1;
    localparam int SHIFT = frac_bits - adc_bits + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [TW-1:0]        tick_cnt_r;
    logic                 tick_s;
    logic [HW-1:0]        half_cnt_r, half_cnt_s;
    logic [4:0]           hp_cnt_r, hp_cnt_s;
    logic                 sclk_r, sclk_s;
    logic                 cs_n_r, cs_n_s;
    // Only adc_bits wide: the four leading zeros of the frame shift out the top.
    logic [adc_bits-1:0]  shift_r, shift_s;
    logic [cant_bits-1:0] u_r, u_s;
    logic                 rx_r, rx_s;
    logic                 half_end_s;

    // Offset-binary code -> two's complement, sign-extended and scaled so
    // that ADC full scale lands on +/-1.0 in the output format.
    function automatic logic [cant_bits-1:0] to_fixed(input logic [adc_bits-1:0] code);
        logic [adc_bits-1:0]  s;
        logic [cant_bits-1:0] ext;
        s   = {~code[adc_bits-1], code[adc_bits-2:0]};
        ext = {{(cant_bits-adc_bits){s[adc_bits-1]}}, s};
        return ext << SHIFT;
    endfunction

    assign tick_s     = (tick_cnt_r == TW'(muestra_ciclos - 1));
    assign half_end_s = (half_cnt_r == HW'(div_sclk - 1));

    // Free-running sample-period counter; runs in every FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Frame sequencer: next state plus next value of every registered output.
    always_comb begin
        state_s    = state_r;
        half_cnt_s = half_cnt_r;
        hp_cnt_s   = hp_cnt_r;
        sclk_s     = sclk_r;
        cs_n_s     = cs_n_r;
        shift_s    = shift_r;
        u_s        = u_r;
        rx_s       = 1'b0;
        case (state_r)
            IDLE: begin
                cs_n_s = 1'b1;
                sclk_s = 1'b1;
                if (tick_s) begin
                    state_s    = CONV;
                    cs_n_s     = 1'b0;
                    sclk_s     = 1'b0;   // first half-period is low
                    half_cnt_s = '0;
                    hp_cnt_s   = 5'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                if (half_end_s) begin
                    half_cnt_s = '0;
                    if (hp_cnt_r == 5'd31) begin
                        // sclk is already back high after the 32nd half-period
                        state_s = FMT;
                        cs_n_s  = 1'b1;
                        sclk_s  = 1'b1;
                    end else begin
                        hp_cnt_s = hp_cnt_r + 5'd1;
                        sclk_s   = ~sclk_r;
                        if (!sclk_r) begin
                            // sclk is about to rise: capture the data bit
                            shift_s = {shift_r[adc_bits-2:0], bus.miso};
                        end else begin
                            shift_s = shift_r;
                        end
                    end
                end else begin
                    half_cnt_s = half_cnt_r + HW'(1);
                end
            end
            FMT: begin
                u_s     = to_fixed(shift_r);
                rx_s    = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset also aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            half_cnt_r <= '0;
            hp_cnt_r   <= 5'd0;
            sclk_r     <= 1'b1;
            cs_n_r     <= 1'b1;
            shift_r    <= '0;
            u_r        <= '0;
            rx_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            half_cnt_r <= half_cnt_s;
            hp_cnt_r   <= hp_cnt_s;
            sclk_r     <= sclk_s;
            cs_n_r     <= cs_n_s;
            shift_r    <= shift_s;
            u_r        <= u_s;
            rx_r       <= rx_s;
        end
    end

`ifdef ADC_OVERRUN_EN
    logic overrun_r;

    // Sticky flag: a sample tick arrived while a frame was still busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (tick_s && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.overrun = overrun_r;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.sclk = sclk_r;
    assign bus.cs_n = cs_n_r;
    assign bus.u    = u_r;
    assign bus.rx   = rx_r;
endmodule

// File: tb/tb_adc_muestreo.sv
// tb_adc_muestreo: scoreboard bench for adc_muestreo. An ADC model serves a
// code per frame and pushes the expected sample; a monitor pops and compares
// on every rx strobe and checks frame timing. A second instance with a short
// sample period exercises the overrun flag.
module tb_adc_muestreo;
    logic clk;
    logic rst;

    adc_muestreo_if #(.cant_bits(25)) bus_m ();
    adc_muestreo_if #(.cant_bits(25)) bus_o ();

    adc_muestreo #(
        .cant_bits(25), .frac_bits(15), .adc_bits(12),
        .muestra_ciclos(2268), .div_sclk(3)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus_m.master)
    );

    adc_muestreo #(
        .cant_bits(25), .frac_bits(15), .adc_bits(12),
        .muestra_ciclos(64), .div_sclk(3)
    ) u_dut_ovr (
        .clk(clk), .rst(rst), .bus(bus_o.master)
    );

`ifdef ADC_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int rx_count = 0;
    bit first_pending = 1'b0;
    int code_idx = 0;
    logic [24:0] exp_q[$];

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected output: (code - 2048) scaled by 2^4, in 25-bit two's complement.
    function automatic logic [24:0] exp_u(input logic [11:0] code);
        int s;
        s = int'(code) - 2048;
        return 25'(s * 16);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Posedge counter used for all timing measurements.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ADC model: one code per frame, bits presented after each sclk rise.
    initial begin
        logic [11:0] tbl [4];
        logic [11:0] code;
        logic [15:0] frame;
        tbl[0] = 12'h800; tbl[1] = 12'hFFF; tbl[2] = 12'h000; tbl[3] = 12'h801;
        bus_m.miso = 1'b0;
        bus_o.miso = 1'b0;
        forever begin
            @(negedge bus_m.cs_n);
            if (code_idx < 4) code = tbl[code_idx];
            else code = 12'($urandom_range(0, 4095));
            code_idx++;
            frame = {4'b0000, code};
            exp_q.push_back(exp_u(code));
            for (int i = 15; i >= 0; i--) begin
                bus_m.miso = frame[i];
                @(posedge bus_m.sclk or posedge bus_m.cs_n);
                if (bus_m.cs_n) begin
                    void'(exp_q.pop_back());
                    break;
                end
            end
        end
    end

    // Monitor: samples on the falling clk edge, away from the active edge.
    initial begin
        logic prev_cs, prev_sclk, prev_rx;
        logic [24:0] prev_u;
        logic [24:0] e;
        int cs_fall_cyc, rises, last_rx_cyc;
        bit last_valid;
        prev_cs = 1'b1; prev_sclk = 1'b1; prev_rx = 1'b0; prev_u = '0;
        cs_fall_cyc = 0; rises = 0; last_rx_cyc = 0; last_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_valid = 1'b0;
            end else begin
                if (prev_cs && !bus_m.cs_n) begin
                    cs_fall_cyc = cyc;
                    rises = 0;
                    if (first_pending) begin
                        check("first_frame_delay", 32'(cyc - rel_cyc), 32'd2268);
                        first_pending = 1'b0;
                    end
                end
                if (!prev_cs && bus_m.cs_n)
                    check("cs_low_len", 32'(cyc - cs_fall_cyc), 32'd96);
                if (!bus_m.cs_n && !prev_sclk && bus_m.sclk)
                    rises++;
                if (bus_m.rx) begin
                    rx_count++;
                    check("rx_width", 32'(prev_rx), 32'd0);
                    check("rx_latency", 32'(cyc - cs_fall_cyc), 32'd97);
                    check("sclk_rises", 32'(rises), 32'd16);
                    check("overrun_main", 32'(bus_m.overrun), 32'd0);
                    if (last_valid)
                        check("rx_period", 32'(cyc - last_rx_cyc), 32'd2268);
                    last_rx_cyc = cyc;
                    last_valid = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("u_data", 32'(bus_m.u), 32'(e));
                    end
                end else begin
                    check("u_hold", 32'(bus_m.u), 32'(prev_u));
                end
            end
            prev_cs = bus_m.cs_n;
            prev_sclk = bus_m.sclk;
            prev_rx = bus_m.rx;
            prev_u = bus_m.u;
        end
    end

    // Assert rst for 5 clocks, release, then check the reset state.
    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        rel_cyc = cyc;
        first_pending = 1'b1;
        @(negedge clk);
        check("rst_u", 32'(bus_m.u), 32'd0);
        check("rst_rx", 32'(bus_m.rx), 32'd0);
        check("rst_cs_n", 32'(bus_m.cs_n), 32'd1);
        check("rst_sclk", 32'(bus_m.sclk), 32'd1);
        check("rst_overrun", 32'(bus_m.overrun), 32'd0);
        check("rst_overrun_ovr", 32'(bus_o.overrun), 32'd0);
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("rx_timeout", 32'(rx_count >= target), 32'd1);
    endtask

    initial begin
        int n;
        int snap;
        rst = 1'b1;
        do_reset();

        // Short-period instance: a tick lands mid-frame well within 200 clocks.
        repeat (200) @(posedge clk);
        #1;
        check("overrun_set", 32'(bus_o.overrun), 32'(EXP_OVR));
        repeat (300) @(posedge clk);
        #1;
        check("overrun_sticky", 32'(bus_o.overrun), 32'(EXP_OVR));

        // Directed codes then random ones: 14 consecutive samples.
        wait_rx(14, 14 * 2268 + 3000);

        // Abort a frame 40 clocks in with rst.
        n = 0;
        while (bus_m.cs_n !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("abort_frame_start", 32'(bus_m.cs_n), 32'd0);
        snap = rx_count;
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs_n", 32'(bus_m.cs_n), 32'd1);
        check("abort_sclk", 32'(bus_m.sclk), 32'd1);
        do_reset();
        check("abort_no_rx", 32'(rx_count), 32'(snap));
        wait_rx(snap + 1, 2268 + 500);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
